// File: rtl/bin_para_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// optional leading-zero blanking and a sign flag for signed inputs.
module bin_para_bcd_soma3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
endmodule

module bin_para_bcd #(
  parameter int LARGURA      = 16,
  parameter int DIGITOS      = 5,
  parameter bit APAGAR_ZEROS = 1'b1
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic [LARGURA-1:0]     i_Entrada,
  input  logic                   i_Com_Sinal,
  input  logic                   i_Iniciar,
  output logic                   o_Ocupado,
  output logic                   o_Pronto,
  output logic                   o_Negativo,
  output logic [4*DIGITOS-1:0]   o_Digitos
);
  localparam int CW = $clog2(LARGURA + 1);

  typedef enum logic [1:0] {OCIOSO, DESLOCA, FIM} estado_t;

  estado_t               r_estado, w_prox;
  logic [LARGURA-1:0]    r_bin;
  logic [4*DIGITOS-1:0]  r_bcd;
  logic [CW-1:0]         r_cont;
  logic                  r_sinal;
  logic                  r_pronto;
  logic                  r_neg;
  logic [4*DIGITOS-1:0]  r_dig;

  logic                  w_aceita;
  logic                  w_passo;
  logic                  w_fim;
  logic                  w_neg_in;
  logic [LARGURA-1:0]    w_mag;
  logic [4*DIGITOS-1:0]  w_corr;
  logic [4*DIGITOS-1:0]  w_blank;
  logic                  w_lead;

  // Add-3 correction on every scratch nibble in parallel
  for (genvar g = 0; g < DIGITOS; g++) begin : g_corr
    bin_para_bcd_soma3 u_soma3 (
      .i_nib (r_bcd[4*g +: 4]),
      .o_nib (w_corr[4*g +: 4])
    );
  end

  assign w_neg_in = i_Com_Sinal & i_Entrada[LARGURA-1];
  // -MIN wraps to 2^(LARGURA-1), which reads correctly as unsigned
  assign w_mag    = w_neg_in ? -i_Entrada : i_Entrada;

  always_comb begin
    w_prox   = r_estado;
    w_aceita = 1'b0;
    w_passo  = 1'b0;
    w_fim    = 1'b0;
    case (r_estado)
      OCIOSO: if (i_Iniciar) begin
        w_aceita = 1'b1;
        w_prox   = DESLOCA;
      end
      DESLOCA: begin
        w_passo = 1'b1;
        if (r_cont == CW'(1)) w_prox = FIM;
      end
      FIM: begin
        w_fim  = 1'b1;
        w_prox = OCIOSO;
      end
      default: w_prox = OCIOSO;
    endcase
  end

  // Only zeros with nothing but zeros above them are blanked; units stay
  always_comb begin
    w_blank = r_bcd;
    w_lead  = 1'b1;
    for (int i = DIGITOS - 1; i >= 1; i--) begin
      if (w_lead && r_bcd[4*i +: 4] == 4'h0) begin
        if (APAGAR_ZEROS) w_blank[4*i +: 4] = 4'hF;
      end else begin
        w_lead = 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) r_estado <= OCIOSO;
    else          r_estado <= w_prox;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cont   <= '0;
      r_sinal  <= 1'b0;
      r_pronto <= 1'b0;
      r_neg    <= 1'b0;
      r_dig    <= '0;
    end else begin
      r_pronto <= w_fim;
      if (w_aceita) begin
        r_bin   <= w_mag;
        r_bcd   <= '0;
        r_cont  <= CW'(LARGURA);
        r_sinal <= w_neg_in;
      end
      if (w_passo) begin
        r_bcd  <= {w_corr[4*DIGITOS-2:0], r_bin[LARGURA-1]};
        r_bin  <= {r_bin[LARGURA-2:0], 1'b0};
        r_cont <= r_cont - CW'(1);
      end
      if (w_fim) begin
        r_dig <= w_blank;
        r_neg <= r_sinal;
      end
    end
  end

  assign o_Ocupado  = (r_estado == DESLOCA) || (r_estado == FIM);
  assign o_Pronto   = r_pronto;
  assign o_Negativo = r_neg;
  assign o_Digitos  = r_dig;
endmodule

// File: tb/tb_bin_para_bcd.sv
// Randomized self-checking bench for bin_para_bcd against a decimal reference model.
module tb_bin_para_bcd;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] entrada;
  logic        com_sinal;
  logic        iniciar;
  logic        ocup, pronto, neg;
  logic [19:0] dig;
  logic        ocup0, pronto0, neg0;
  logic [19:0] dig0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bin_para_bcd #(.LARGURA(16), .DIGITOS(5), .APAGAR_ZEROS(1'b1)) dut (
    .i_Clock(clk), .i_Reset(rst_n), .i_Entrada(entrada), .i_Com_Sinal(com_sinal),
    .i_Iniciar(iniciar), .o_Ocupado(ocup), .o_Pronto(pronto), .o_Negativo(neg),
    .o_Digitos(dig));

  bin_para_bcd #(.LARGURA(16), .DIGITOS(5), .APAGAR_ZEROS(1'b0)) dut0 (
    .i_Clock(clk), .i_Reset(rst_n), .i_Entrada(entrada), .i_Com_Sinal(com_sinal),
    .i_Iniciar(iniciar), .o_Ocupado(ocup0), .o_Pronto(pronto0), .o_Negativo(neg0),
    .o_Digitos(dig0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference: magnitude by arithmetic, digits by /10, blanking by scan
  function automatic logic [19:0] ref_dig(input logic [15:0] v, input bit s, input bit blank);
    int unsigned m;
    logic [19:0] r;
    bit lead;
    m = (s && v[15]) ? (32'd65536 - 32'(v)) : 32'(v);
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    lead = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (lead && r[4*i +: 4] == 4'h0) begin
        if (blank) r[4*i +: 4] = 4'hF;
      end else lead = 1'b0;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [15:0] v, input bit s, input string tag);
    int cnt;
    logic [19:0] e1, e0;
    e1 = ref_dig(v, s, 1'b1);
    e0 = ref_dig(v, s, 1'b0);
    entrada = v; com_sinal = s; iniciar = 1'b1;
    step();
    iniciar = 1'b0; entrada = 16'($urandom); com_sinal = 1'($urandom);
    cnt = 1;
    chk({tag, "_busy"}, 32'(ocup), 32'd1);
    while (!pronto && cnt < 40) begin
      step();
      cnt++;
    end
    chk({tag, "_lat"}, cnt, 18);
    chk({tag, "_dig"}, 32'(dig), 32'(e1));
    chk({tag, "_dig0"}, 32'(dig0), 32'(e0));
    chk({tag, "_neg"}, 32'(neg), 32'(s & v[15]));
    chk({tag, "_idle"}, 32'(ocup), 32'd0);
    step();
    chk({tag, "_pulse"}, 32'(pronto), 32'd0);
    chk({tag, "_hold"}, 32'(dig), 32'(e1));
  endtask

  initial begin
    int cnt, seen;
    logic [15:0] nxt;
    rst_n = 1'b0; entrada = '0; com_sinal = 1'b0; iniciar = 1'b0;
    repeat (3) step();
    chk("rst_dig", 32'(dig), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    chk("rst_busy", 32'(ocup), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    rst_n = 1'b1;
    step();

    run(16'd0, 1'b0, "zero");
    chk("zero_exact", 32'(dig), 32'hFFFF0);
    run(16'hFFFF, 1'b0, "ffff_u");
    chk("ffff_u_exact", 32'(dig), 32'h65535);
    run(16'hFFFF, 1'b1, "ffff_s");
    chk("ffff_s_exact", 32'(dig), 32'hFFFF1);
    run(16'h8000, 1'b1, "min");
    chk("min_exact", 32'(dig), 32'h32768);
    run(16'd42, 1'b0, "d42");
    chk("d42_noblank", 32'(dig0), 32'h00042);
    run(16'd10000, 1'b0, "d10000");
    run(16'd100, 1'b1, "d100");

    for (int n = 0; n < 30; n++) run(16'($urandom), 1'($urandom), "rnd");

    // Iniciar held high: alternating 1234 / 9, garbage between acceptances
    iniciar = 1'b1; com_sinal = 1'b0; nxt = 16'd1234;
    for (int r = 0; r < 4; r++) begin
      logic [15:0] cur;
      cur = nxt;
      entrada = cur;
      cnt = 0;
      do begin
        step();
        entrada = 16'($urandom);
        cnt++;
      end while (!pronto && cnt < 40);
      chk("b2b_period", cnt, 18);
      chk("b2b_dig", 32'(dig), 32'(ref_dig(cur, 1'b0, 1'b1)));
      chk("b2b_dig0", 32'(dig0), 32'(ref_dig(cur, 1'b0, 1'b0)));
      nxt = (cur == 16'd1234) ? 16'd9 : 16'd1234;
      if (r == 3) iniciar = 1'b0;
    end
    step();

    // Iniciar while busy is ignored
    entrada = 16'd500; com_sinal = 1'b0; iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    repeat (3) step();
    entrada = 16'd777; iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    cnt = 5; seen = 0;
    while (!pronto && cnt < 40) begin step(); cnt++; end
    chk("busy_lat", cnt, 18);
    chk("busy_dig", 32'(dig), 32'(ref_dig(16'd500, 1'b0, 1'b1)));
    for (int i = 0; i < 25; i++) begin step(); if (pronto) seen++; end
    chk("busy_noextra", seen, 0);

    // Reset mid-conversion after a negative result
    run(16'hFFFB, 1'b1, "pre_rst");
    entrada = 16'd1234; iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    step();
    chk("abort_busy", 32'(ocup), 32'd0);
    chk("abort_dig", 32'(dig), 32'd0);
    chk("abort_neg", 32'(neg), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin step(); if (pronto) seen++; end
    chk("abort_nopronto", seen, 0);
    run(16'd99, 1'b0, "d99");
    chk("d99_exact", 32'(dig), 32'hFFF99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bin_para_bcd.md
# bin_para_bcd

Sequential binary-to-BCD converter feeding the board's seven-segment digit decoders. It takes a processor register value and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It then presents one 4-bit BCD nibble per display digit, plus a sign flag. Leading zeros can be replaced by the blank code 4'hF, which the digit decoder renders as all segments off.

## Interface

Parameters:
- LARGURA, 16, width of the binary input in bits.
- DIGITOS, 5, number of BCD digits produced; must satisfy 10^DIGITOS > 2^LARGURA − 1.
- APAGAR_ZEROS, 1, when 1 leading-zero digits are output as 4'hF; when 0 they are output as 4'h0.

Ports:
- Clock  input  1  single clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-low reset.
- Entrada  input  LARGURA  binary value, sampled only on the accepting edge.
- Com_Sinal  input  1  1 = Entrada is two's complement; 0 = unsigned; sampled with Entrada.
- Iniciar  input  1  start request; honoured only when Ocupado = 0.
- Ocupado  output  1  high while a conversion is in progress.
- Pronto  output  1  one-cycle pulse: Digitos/Negativo just updated.
- Negativo  output  1  1 when the last converted value was negative (Com_Sinal = 1 and MSB = 1).
- Digitos  output  4*DIGITOS  BCD result; digit 0 (units) in bits [3:0], digit i in bits [4i+3:4i].

## Operation

- Reset (Reset = 0 at an edge): state OCIOSO, Ocupado = 0, Pronto = 0, Negativo = 0, Digitos = all 4'h0, scratch registers and counter cleared. Reset during a conversion aborts it and produces no Pronto.
- FSM states: OCIOSO, DESLOCA, FIM.
- OCIOSO, Iniciar = 1:
  - Magnitude: if Com_Sinal = 1 and Entrada[LARGURA−1] = 1, use the two's complement of Entrada, else Entrada unchanged.
  - Capture the magnitude into a LARGURA-bit shift register; latch the sign into an internal flag.
  - Clear the BCD scratch (4*DIGITOS bits); load the counter with LARGURA; go to DESLOCA.
  - The most negative value, e.g. −32768 at 16 bits, has magnitude 2^(LARGURA−1), which fits unsigned.
- DESLOCA, each cycle:
  - Correction: every scratch nibble ≥ 5 gets 3 added, all nibbles in parallel.
  - Shift: the concatenation {scratch, shift register} shifts left by 1; the binary MSB enters scratch bit 0.
  - The counter decrements; when the step just performed is the last (counter was 1), go to FIM.
- FIM (one cycle):
  - Copy scratch to Digitos, applying blanking; copy the sign flag to Negativo.
  - Pulse Pronto = 1 for exactly one cycle; return to OCIOSO.
- Blanking (APAGAR_ZEROS = 1): scanning from the most significant digit down, each digit that is 0 and has only zeros above it is output as 4'hF. Digit 0 is never blanked, so a result of 0 shows as units 4'h0.
- Digitos and Negativo hold their value between Pronto pulses; they never show intermediate scratch contents.
- Iniciar while Ocupado = 1 is ignored: no queueing, no effect on the current conversion.
- Ocupado = 1 exactly when the state is DESLOCA or FIM.

## Timing

- Iniciar is accepted at edge k (state OCIOSO). Then:
  - Edges k+1 … k+LARGURA perform the LARGURA shift steps.
  - Edge k+LARGURA+1 performs the FIM update.
- Ocupado is high from after edge k until after edge k+LARGURA+1.
- Pronto is high, and the new Digitos/Negativo are valid, during the cycle following edge k+LARGURA+1. The default latency is 18 cycles.
- Back-to-back: Iniciar high during the Pronto cycle is accepted (the state is OCIOSO). Maximum throughput is one result per LARGURA+2 cycles.
- Pronto and Iniciar acceptance can coincide; the new conversion does not disturb the just-published Digitos until its own FIM.

## Test plan

- Reset, then Entrada = 0, Com_Sinal = 0, Iniciar pulse → Pronto exactly 18 cycles later; Digitos = F,F,F,F,0 (MSD→LSD); Negativo = 0.
- Entrada = 16'hFFFF with Com_Sinal = 0 → Digitos = 6,5,5,3,5, Negativo = 0. Repeat with Com_Sinal = 1 → Digitos = F,F,F,F,1, Negativo = 1.
- Entrada = 16'h8000 with Com_Sinal = 1 → Digitos = 3,2,7,6,8, Negativo = 1. Repeat with APAGAR_ZEROS = 0 and Entrada = 42 → Digitos = 0,0,0,4,2.
- Iniciar held high continuously, Entrada alternating 1234 / 9 at each acceptance:
  - Accepted every 18 cycles, Pronto every 18 cycles.
  - Results alternate F,1,2,3,4 and F,F,F,F,9.
  - Mid-conversion changes to Entrada have no effect.
- Start a conversion of 500, and pulse Iniciar with 777 while Ocupado = 1 → result 500; 777 never appears.
- Start a conversion, and assert Reset = 0 at cycle 8 → no Pronto; Ocupado = 0; Digitos = 0 and Negativo = 0 on the next cycle. A subsequent conversion of 99 yields F,F,F,9,9.
